key_scheduler: RTL and testbench

Debounce scheduler for the lab front-panel keys. It shares one settle counter among N_KEYS raw push-buttons, granting it round-robin, so N keys need one counter instead of N per-key debouncers. It commits a key's new level only after the level has held for SETTLE_CYC cycles. Each committed press or release goes out as one event over a valid/ready handshake to the BCD display controller.

---
 rtl/key_sched_pkg.sv | 13 +
 rtl/key_scheduler_sync_2ff.sv | 25 ++
 rtl/key_scheduler.sv | 117 +++++++++++
 tb/tb_key_scheduler.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_sched_pkg.sv
// Shared types and default parameters for the front-panel key debounce scheduler.
package key_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      COMMIT
   } state_t;

   localparam int N_KEYS_DEF     = 4;
   localparam int SETTLE_CYC_DEF = 10;

endpackage

// File: rtl/key_scheduler_sync_2ff.sv
// Two-flop synchronizer bank that brings the raw button levels into the clk domain.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // First stage may go metastable; the second stage gives it a full cycle to resolve.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         // NOTE: non-blocking assignments let both stages sample the old value on the same edge, forming a real two-flop chain.
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/key_scheduler.sv
// Round-robin debounce scheduler: one settle counter shared by all keys, one event per committed level change.
module key_scheduler
   import key_sched_pkg::*;
#(
   parameter int N_KEYS     = N_KEYS_DEF,
   parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
   input  logic                      clk,
   input  logic                      rst_ext_n,
   input  logic [N_KEYS-1:0]         key_raw,
   output logic                      evt_valid,
   output logic [$clog2(N_KEYS)-1:0] evt_key,
   output logic                      evt_press,
   input  logic                      evt_ready,
   output logic [N_KEYS-1:0]         key_state,
   output logic                      busy
);

   localparam int IDX_W = $clog2(N_KEYS);
   localparam int CNT_W = $clog2(SETTLE_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

   state_t            state;
   logic [N_KEYS-1:0] ks;
   logic [N_KEYS-1:0] mismatch;
   logic [IDX_W-1:0]  ptr;
   logic [IDX_W-1:0]  cur;
   logic              tgt;
   logic [CNT_W-1:0]  cnt;
   logic              scan_hit;
   logic [IDX_W-1:0]  scan_idx;
   logic [IDX_W:0]    scan_pos;

   sync_2ff #(.WIDTH(N_KEYS)) u_sync (
      .clk   (clk),
      .rst_n (rst_ext_n),
      .d     (key_raw),
      .q     (ks)
   );

   // Next key index after idx, wrapping at N_KEYS (which need not be a power of two).
   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
      if (idx == IDX_W'(N_KEYS - 1))
         return '0;
      return idx + 1'b1;
   endfunction

   assign mismatch = ks ^ key_state;
   assign busy     = (state != IDLE);

   // Find the first mismatching key at or after ptr, wrapping; the lowest offset from ptr wins.
   always_comb begin
      // NOTE: every variable gets a default before the loop so no path leaves it unassigned, which would infer a latch.
      scan_hit = 1'b0;
      scan_idx = '0;
      scan_pos = '0;
      for (int off = N_KEYS - 1; off >= 0; off--) begin
         scan_pos = {1'b0, ptr} + (IDX_W + 1)'(off);
         if (scan_pos >= (IDX_W + 1)'(N_KEYS))
            scan_pos = scan_pos - (IDX_W + 1)'(N_KEYS);
         if (mismatch[scan_pos[IDX_W-1:0]]) begin
            scan_hit = 1'b1;
            scan_idx = scan_pos[IDX_W-1:0];
         end
      end
   end

   // Scheduler FSM: grant a key, watch it settle, then hold the event until the consumer takes it.
   always_ff @(posedge clk or negedge rst_ext_n) begin
      if (!rst_ext_n) begin
         state     <= IDLE;
         ptr       <= '0;
         cur       <= '0;
         tgt       <= 1'b0;
         cnt       <= '0;
         evt_valid <= 1'b0;
         evt_key   <= '0;
         evt_press <= 1'b0;
         key_state <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (scan_hit) begin
                  cur   <= scan_idx;
                  tgt   <= ks[scan_idx];
                  cnt   <= '0;
                  state <= SETTLE;
               end
            end
            SETTLE: begin
               if (ks[cur] != tgt) begin
                  // Bounce: give up and move past this key so a chattering key cannot hog the counter.
                  ptr   <= wrap_inc(cur);
                  state <= IDLE;
               end else if (cnt == CNT_LAST) begin
                  evt_valid <= 1'b1;
                  evt_key   <= cur;
                  evt_press <= tgt;
                  state     <= COMMIT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            COMMIT: begin
               if (evt_ready) begin
                  key_state[cur] <= tgt;
                  ptr            <= wrap_inc(cur);
                  evt_valid      <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_key_scheduler.sv
// Scoreboard bench for key_scheduler: stimulus pushes expected events, a monitor pops them on each handshake.
module tb_key_scheduler;

   localparam int N_KEYS     = 4;
   localparam int SETTLE_CYC = 10;

   typedef struct {
      logic [1:0] key;
      logic       press;
   } evt_t;

   logic              clk;
   logic              rst_ext_n;
   logic [N_KEYS-1:0] key_raw;
   logic              evt_valid;
   logic [1:0]        evt_key;
   logic              evt_press;
   logic              evt_ready;
   logic [N_KEYS-1:0] key_state;
   logic              busy;

   evt_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   key_scheduler #(.N_KEYS(N_KEYS), .SETTLE_CYC(SETTLE_CYC)) dut (
      .clk       (clk),
      .rst_ext_n (rst_ext_n),
      .key_raw   (key_raw),
      .evt_valid (evt_valid),
      .evt_key   (evt_key),
      .evt_press (evt_press),
      .evt_ready (evt_ready),
      .key_state (key_state),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   task automatic push(input logic [1:0] key, input logic press);
      evt_t e;
      e.key   = key;
      e.press = press;
      exp_q.push_back(e);
   endtask

   // Drive point: just after a rising edge, so the next rising edge is the capture edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Count rising edges until evt_valid is seen; n = -1 when the budget runs out.
   task automatic wait_valid(input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         @(posedge clk);
         #1;
         if (evt_valid) begin
            n = i;
            break;
         end
      end
   endtask

   // Monitor: each handshake seen at the falling edge must match the oldest expected event.
   initial begin : monitor
      evt_t e;
      forever begin
         @(negedge clk);
         if (rst_ext_n && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL evt_unexpected: got key=%0d press=%0b expected no event (t=%0t)",
                        evt_key, evt_press, $time);
            end else begin
               e = exp_q.pop_front();
               check("evt_key", 32'(evt_key), 32'(e.key));
               check("evt_press", 32'(evt_press), 32'(e.press));
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int n;
      int nb;
      int nv;

      rst_ext_n = 1'b0;
      key_raw   = '0;
      evt_ready = 1'b1;
      #1;
      check("rst_evt_valid", 32'(evt_valid), 32'd0);
      check("rst_evt_key", 32'(evt_key), 32'd0);
      check("rst_evt_press", 32'(evt_press), 32'd0);
      check("rst_key_state", 32'(key_state), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      repeat (3) @(posedge clk);
      #2;
      rst_ext_n = 1'b1;
      repeat (3) step();

      // Simultaneous rise of keys 0 and 3 with ptr at 0.
      push(2'd0, 1'b1);
      push(2'd3, 1'b1);
      key_raw = 4'b1001;
      @(posedge clk);
      wait_valid(20, n);
      check("sim_key0_latency", 32'(n), 32'd12);
      check("sim_key0_idx", 32'(evt_key), 32'd0);
      @(posedge clk);
      #1;
      check("sim_key0_one_cycle", 32'(evt_valid), 32'd0);
      wait_valid(20, n);
      check("sim_key3_after_hs", 32'(n), 32'd11);
      check("sim_key3_idx", 32'(evt_key), 32'd3);
      @(posedge clk);
      #1;
      check("sim_key_state", 32'(key_state), 32'h9);

      // Release both: two release events, key0 first since ptr wrapped back to 0.
      push(2'd0, 1'b0);
      push(2'd3, 1'b0);
      step();
      key_raw = 4'b0000;
      repeat (40) @(posedge clk);
      #1;
      check("rel_key_state", 32'(key_state), 32'h0);
      check("rel_queue_empty", 32'(exp_q.size()), 32'd0);

      // Clean press of key1.
      push(2'd1, 1'b1);
      step();
      key_raw[1] = 1'b1;
      @(posedge clk);
      wait_valid(20, n);
      check("clean_latency", 32'(n), 32'd12);
      check("clean_key", 32'(evt_key), 32'd1);
      check("clean_press", 32'(evt_press), 32'd1);
      check("clean_state_before_hs", 32'(key_state), 32'h0);
      @(posedge clk);
      #1;
      check("clean_one_cycle", 32'(evt_valid), 32'd0);
      check("clean_key_state", 32'(key_state), 32'h2);

      // Bounce: key2 high for five cycles only.
      repeat (3) step();
      key_raw[2] = 1'b1;
      nb = 0;
      nv = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (busy) nb++;
         if (evt_valid) nv++;
         if (i == 5) key_raw[2] = 1'b0;
      end
      check("bounce_busy_seen", 32'(nb > 0), 32'd1);
      check("bounce_busy_le7", 32'(nb <= 7), 32'd1);
      check("bounce_no_valid", 32'(nv), 32'd0);
      check("bounce_key_state", 32'(key_state), 32'h2);

      // Backpressure: key2 press with the consumer stalled for 20 cycles.
      evt_ready = 1'b0;
      push(2'd2, 1'b1);
      step();
      key_raw[2] = 1'b1;
      @(posedge clk);
      wait_valid(20, n);
      check("bp_latency", 32'(n), 32'd12);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         check("bp_valid_held", 32'(evt_valid), 32'd1);
         check("bp_key_held", 32'(evt_key), 32'd2);
         check("bp_press_held", 32'(evt_press), 32'd1);
         check("bp_state_waits", 32'(key_state[2]), 32'd0);
      end
      #1;
      evt_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_state_after", 32'(key_state), 32'h6);
      check("bp_valid_drop", 32'(evt_valid), 32'd0);

      // Reset mid-SETTLE: key2 release in progress is discarded, key1 re-presses afterwards.
      step();
      key_raw[2] = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("mid_settle_busy", 32'(busy), 32'd1);
      #1;
      rst_ext_n = 1'b0;
      #1;
      check("mrst_evt_valid", 32'(evt_valid), 32'd0);
      check("mrst_evt_key", 32'(evt_key), 32'd0);
      check("mrst_evt_press", 32'(evt_press), 32'd0);
      check("mrst_key_state", 32'(key_state), 32'd0);
      check("mrst_busy", 32'(busy), 32'd0);
      push(2'd1, 1'b1);
      step();
      rst_ext_n = 1'b1;
      @(posedge clk);
      wait_valid(20, n);
      check("post_rst_latency", 32'(n), 32'd12);
      @(posedge clk);
      #1;
      check("post_rst_key_state", 32'(key_state), 32'h2);

      // Release key1 so fairness starts from a clean slate.
      push(2'd1, 1'b0);
      step();
      key_raw[1] = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("pre_fair_key_state", 32'(key_state), 32'h0);

      // Fairness: key0 chatters every 3 cycles while key1 is pressed and held.
      push(2'd1, 1'b1);
      step();
      key_raw[1] = 1'b1;
      key_raw[0] = 1'b1;
      fork
         begin
            for (int t = 0; t < 13; t++) begin
               repeat (3) @(posedge clk);
               #2;
               key_raw[0] = ~key_raw[0];
            end
         end
         begin
            @(posedge clk);
            wait_valid(2 * (SETTLE_CYC + 3), n);
            check("fair_within_bound", 32'(n > 0), 32'd1);
            check("fair_key", 32'(evt_key), 32'd1);
         end
      join
      repeat (30) @(posedge clk);
      #1;
      check("fair_key_state", 32'(key_state), 32'h2);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
